// File: rtl/l2_bus_arbiter_pkg.sv
// Shared arbitration encodings for the L2 bus arbiter and the cores that talk to it.
// LOG2 gives a minimum width of 1 so single-bit owner indices stay legal.
`ifndef L2_BUS_ARBITER_LOG2
`define L2_BUS_ARBITER_LOG2
`define LOG2(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package l2_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_GRANT      = 2'd1,
    ARB_TURNAROUND = 2'd2
  } arb_state_e;

  localparam logic BUS_GRANTED       = 1'b1;
  localparam logic BUS_NOT_GRANTED   = 1'b0;
  localparam logic BUS_REQUESTED     = 1'b1;
  localparam logic BUS_NOT_REQUESTED = 1'b0;

endpackage

// File: rtl/l2_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or above the pointer, wrapping.
module rr_priority_picker
  import l2_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_WIDTH   = 1
) (
  input  logic [NUM_MASTERS-1:0] request,
  input  logic [IDX_WIDTH-1:0]   pointer,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [IDX_WIDTH-1:0]   index,
  output logic                   valid
);

  int cand;

  always_comb begin
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (int'(pointer) + i) % NUM_MASTERS;
      if (!valid && request[cand] == BUS_REQUESTED) begin
        valid        = 1'b1;
        winner[cand] = BUS_GRANTED;
        index        = IDX_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Registered round-robin arbiter for the shared L2 bus; steers the owner's address to L2.
//   state          | meaning
//   ARB_IDLE       | no owner, arbitrate among current requests
//   ARB_GRANT      | owner holds the bus until it drops its request
//   ARB_TURNAROUND | one dead cycle for bus settling, arbitrate again
module l2_bus_arbiter
  import l2_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 4,
  parameter int MAX_HOLD    = 8
) (
  input  logic                              clk,
  input  logic                              reset_in,
  input  logic [NUM_MASTERS-1:0]            bus_request_in,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr_in,
  output logic [NUM_MASTERS-1:0]            bus_grant_out,
  output logic [ADDR_WIDTH-1:0]             l2_addr_out,
  output logic [`LOG2(NUM_MASTERS)-1:0]     owner_out,
  output logic                              bus_busy_out,
  output logic                              timeout_out
);

  localparam int IW = `LOG2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_MASTERS - 1);
  localparam logic [CW-1:0] HOLD_SAT  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_WARN = CW'(MAX_HOLD - 1);

  arb_state_e               state;
  logic [IW-1:0]            ptr;
  logic [CW-1:0]            hold;
  logic [NUM_MASTERS-1:0]   pick_winner;
  logic [IW-1:0]            pick_index;
  logic                     pick_valid;
  logic                     owner_req;
  logic                     others_req;

  rr_priority_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_WIDTH  (IW)
  ) u_picker (
    .request(bus_request_in),
    .pointer(ptr),
    .winner (pick_winner),
    .index  (pick_index),
    .valid  (pick_valid)
  );

  assign owner_req    = (bus_request_in[owner_out] == BUS_REQUESTED);
  // The grant vector is the owner mask while in GRANT.
  assign others_req   = |(bus_request_in & ~bus_grant_out);
  assign bus_busy_out = |bus_grant_out;

  always_comb begin
    l2_addr_out = '0;
    if (bus_busy_out) l2_addr_out = addr_in[owner_out*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state         <= ARB_IDLE;
      ptr           <= '0;
      hold          <= '0;
      bus_grant_out <= '0;
      owner_out     <= '0;
      timeout_out   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE, ARB_TURNAROUND: begin
          if (pick_valid) begin
            bus_grant_out <= pick_winner;
            owner_out     <= pick_index;
            hold          <= '0;
            state         <= ARB_GRANT;
          end else begin
            bus_grant_out <= '0;
            state         <= ARB_IDLE;
          end
        end
        ARB_GRANT: begin
          if (hold == HOLD_WARN && others_req) timeout_out <= 1'b1;
          if (owner_req) begin
            if (hold != HOLD_SAT) hold <= hold + 1'b1;
          end else begin
            bus_grant_out <= {NUM_MASTERS{BUS_NOT_GRANTED}};
            ptr           <= (owner_out == LAST_IDX) ? '0 : owner_out + 1'b1;
            state         <= ARB_TURNAROUND;
          end
        end
        default: begin
          bus_grant_out <= '0;
          state         <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Bench for l2_bus_arbiter: directed scenarios plus randomized traffic against an ownership model.
module tb_l2_bus_arbiter;

  localparam int N        = 2;
  localparam int AW       = 4;
  localparam int MAX_HOLD = 8;
  localparam int AV       = N * AW;

  logic          clk = 1'b0;
  logic          reset_in = 1'b0;
  logic [N-1:0]  req = '0;
  logic [AV-1:0] addr = '0;
  logic [N-1:0]  grant;
  logic [AW-1:0] l2_addr;
  logic          owner;
  logic          busy;
  logic          timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the bus, how many cycles it has been visibly granted, next-start pointer.
  int m_owner = -1;
  int m_cycles = 0;
  int m_ptr = 0;
  bit m_timeout = 1'b0;

  l2_bus_arbiter #(
    .NUM_MASTERS(N),
    .ADDR_WIDTH (AW),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk           (clk),
    .reset_in      (reset_in),
    .bus_request_in(req),
    .addr_in       (addr),
    .bus_grant_out (grant),
    .l2_addr_out   (l2_addr),
    .owner_out     (owner),
    .bus_busy_out  (busy),
    .timeout_out   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_owner   = -1;
    m_cycles  = 0;
    m_ptr     = 0;
    m_timeout = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    bit found;
    int c;
    if (m_owner >= 0) begin
      if (m_cycles == MAX_HOLD && (r & ~(N'(1) << m_owner)) != '0) m_timeout = 1'b1;
      if (r[m_owner]) m_cycles++;
      else begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && r[c]) begin
          found    = 1'b1;
          m_owner  = c;
          m_cycles = 1;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    if (m_owner < 0) return '0;
    return N'(1) << m_owner;
  endfunction

  function automatic logic [AW-1:0] exp_addr();
    if (m_owner < 0) return '0;
    return addr[m_owner*AW +: AW];
  endfunction

  task automatic drive(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(req);
    #1;
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    req = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_in = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL reset_grant got %b want 00", grant); end
    n_cmp++; if (l2_addr !== '0) begin n_err++; $display("FAIL reset_addr got %h want 0", l2_addr); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL reset_owner got %b want 0", owner); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", timeout); end
  endtask

  task automatic test_single();
    do_reset();
    addr = 8'hA5;
    for (int c = 0; c < 5; c++) begin
      drive(c < 3 ? 2'b01 : 2'b00);
      step();
      n_cmp++; if (grant !== exp_grant()) begin n_err++; $display("FAIL single_grant c=%0d got %b want %b", c, grant, exp_grant()); end
      n_cmp++; if (l2_addr !== exp_addr()) begin n_err++; $display("FAIL single_addr c=%0d got %h want %h", c, l2_addr, exp_addr()); end
      if (c == 0) begin
        n_cmp++; if (grant !== 2'b01 || l2_addr !== 4'h5) begin n_err++; $display("FAIL single_first got %b/%h want 01/5", grant, l2_addr); end
      end
      if (c == 3) begin
        n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL single_release got %b want 00", grant); end
      end
    end
  endtask

  task automatic test_alternate();
    logic [N-1:0] seq [8];
    logic [N-1:0] r;
    seq = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
    do_reset();
    addr = 8'h7E;
    for (int c = 0; c < 8; c++) begin
      r = (m_owner >= 0 && m_cycles >= 2) ? (2'b11 & ~(N'(1) << m_owner)) : 2'b11;
      drive(r);
      step();
      n_cmp++; if (grant !== seq[c]) begin n_err++; $display("FAIL alt_seq c=%0d got %b want %b", c, grant, seq[c]); end
      n_cmp++; if (grant !== exp_grant()) begin n_err++; $display("FAIL alt_model c=%0d got %b want %b", c, grant, exp_grant()); end
      n_cmp++; if (l2_addr !== exp_addr()) begin n_err++; $display("FAIL alt_addr c=%0d got %h want %h", c, l2_addr, exp_addr()); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    addr = 8'h3C;
    for (int c = 0; c < 13; c++) begin
      drive(c == 0 ? 2'b10 : (c <= 9 ? 2'b11 : 2'b01));
      step();
      n_cmp++; if (timeout !== (c >= MAX_HOLD)) begin n_err++; $display("FAIL to_flag c=%0d got %b want %b", c, timeout, c >= MAX_HOLD); end
      n_cmp++; if (timeout !== m_timeout) begin n_err++; $display("FAIL to_model c=%0d got %b want %b", c, timeout, m_timeout); end
      n_cmp++; if (grant !== exp_grant()) begin n_err++; $display("FAIL to_grant c=%0d got %b want %b", c, grant, exp_grant()); end
      if (c == 11) begin
        n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL to_next got %b want 01", grant); end
      end
    end
  endtask

  task automatic test_pulse();
    logic [N-1:0] pat [7];
    pat = '{2'b01, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    do_reset();
    addr = 8'h42;
    for (int c = 0; c < 7; c++) begin
      drive(pat[c]);
      step();
      n_cmp++; if (grant[1] !== 1'b0) begin n_err++; $display("FAIL pulse_core1 c=%0d got %b want 0", c, grant[1]); end
      n_cmp++; if (grant !== exp_grant()) begin n_err++; $display("FAIL pulse_model c=%0d got %b want %b", c, grant, exp_grant()); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    addr = 8'h96;
    drive(2'b10);
    step();
    step();
    n_cmp++; if (grant !== 2'b10 || l2_addr !== 4'h9) begin n_err++; $display("FAIL areset_pre got %b/%h want 10/9", grant, l2_addr); end
    #3;
    reset_in = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL areset_grant got %b want 00", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy got %b want 0", busy); end
    n_cmp++; if (l2_addr !== '0) begin n_err++; $display("FAIL areset_addr got %h want 0", l2_addr); end
    drive(2'b11);
    reset_in = 1'b1;
    step();
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL areset_restart got %b want 01", grant); end
    n_cmp++; if (l2_addr !== 4'h6) begin n_err++; $display("FAIL areset_addr2 got %h want 6", l2_addr); end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      drive(r);
      addr = AV'($urandom);
      step();
      n_cmp++; if (grant !== exp_grant()) begin n_err++; $display("FAIL rand_grant c=%0d got %b want %b", c, grant, exp_grant()); end
      n_cmp++; if (l2_addr !== exp_addr()) begin n_err++; $display("FAIL rand_addr c=%0d got %h want %h", c, l2_addr, exp_addr()); end
      n_cmp++; if (busy !== (m_owner >= 0)) begin n_err++; $display("FAIL rand_busy c=%0d got %b want %b", c, busy, m_owner >= 0); end
      n_cmp++; if (timeout !== m_timeout) begin n_err++; $display("FAIL rand_timeout c=%0d got %b want %b", c, timeout, m_timeout); end
      if (m_owner >= 0) begin
        n_cmp++; if (owner !== 1'(m_owner)) begin n_err++; $display("FAIL rand_owner c=%0d got %0d want %0d", c, owner, m_owner); end
      end
      #2;
      addr = AV'($urandom);
      #1;
      n_cmp++; if (l2_addr !== exp_addr()) begin n_err++; $display("FAIL rand_addr_comb c=%0d got %h want %h", c, l2_addr, exp_addr()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_timeout();
    test_pulse();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
